// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle over WIDTH cycles,
// followed by one sign-correction cycle. The latency is fixed.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_reg, b_reg;     // magnitudes (signed ops) or raw operands
    logic [2*WIDTH-1:0] acc;              // product, or {remainder, quotient}
    logic               is_div;
    logic               neg_q;            // product / quotient must be negated
    logic               neg_r;            // remainder must be negated

    logic               accept;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic               div0;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign accept    = (state == IDLE) && start;
    assign op_signed = ~op[0];
    assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

    // Multiply step: add multiplicand when the current multiplier LSB is set.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{b_reg[0]}} & a_reg};

    // Restoring divide step: bring in the next dividend bit and trial-subtract.
    // The partial remainder stays below 2*divisor, so bit WIDTH of diff is the borrow.
    assign rem_sh = {acc[2*WIDTH-1:WIDTH], a_reg[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, b_reg};
    assign q_bit  = ~diff[WIDTH];

    // Divide by zero leaves quotient all-ones and remainder = |a|; skipping the
    // quotient negate and keeping the dividend-sign remainder negate returns the
    // original a in HI.
    assign div0     = (b_reg == '0);
    assign prod_fix = neg_q ? -acc : acc;
    assign q_fix    = (neg_q && !div0) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: fixed WIDTH iterations, then one correction cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, handshake flags and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hilo_we) begin
                        if (hilo_sel) hi <= hilo_wdata;
                        else          lo <= hilo_wdata;
                    end
                    if (accept) begin
                        a_reg  <= a_mag;
                        b_reg  <= b_mag;
                        is_div <= op[1];
                        neg_q  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= op_signed && a[WIDTH-1];
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc   <= {q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0],
                                  acc[WIDTH-2:0], q_bit};
                        a_reg <= a_reg << 1;
                    end else begin
                        acc   <= {mul_sum, acc[WIDTH-1:1]};
                        b_reg <= b_reg >> 1;
                    end
                end
                FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: cycle-exact handshake,
// signed/unsigned results, divide-by-zero, overflow, direct HI/LO writes,
// ignored start/write while busy, and reset abort.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hilo_we;
    logic        hilo_sel;
    logic [31:0] hilo_wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hilo_we(hilo_we), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Advance one cycle; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one operation in the current cycle (cycle 0) and follow it to the
    // done cycle (34). Returns with the bench sitting in the done cycle so the
    // next call starts back-to-back.
    // mode 0: plain; 1: foreign start + hilo_we mid-run and hilo_we in FIX;
    // 2: hilo_we to HI together with the accepted start.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi,
                          input logic [31:0] elo, input int mode);
        start = 1'b1; op = o; a = x; b = y;
        if (mode == 2) begin
            hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hCAFE_F00D;
        end
        step();
        start = 1'b0; hilo_we = 1'b0;
        if (mode == 2) chk({tag, " we+start hi"}, hi, 32'hCAFE_F00D);
        for (int c = 1; c <= 33; c++) begin
            chk($sformatf("%s busy/done c%0d", tag, c), {30'd0, busy, done}, 32'd2);
            if (mode == 1 && c == 5) begin
                start = 1'b1; op = DIVU; a = 32'd9; b = 32'd3;
                hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h1234_5678;
            end else if (mode == 1 && c == 33) begin
                hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h5555_AAAA;
            end else begin
                start = 1'b0; hilo_we = 1'b0;
            end
            step();
        end
        start = 1'b0; hilo_we = 1'b0;
        chk({tag, " busy/done c34"}, {30'd0, busy, done}, 32'd1);
        chk({tag, " hi"}, hi, ehi);
        chk({tag, " lo"}, lo, elo);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;
        step(); step();
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        reset = 1'b0;
        step();

        // All of these run back-to-back: each start is in the previous done cycle.
        run_op("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("mult -3*5", MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        run_op("div -7/2",  DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        run_op("divu 7/0",  DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 0);
        run_op("div -7/0",  DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
        run_op("divu 100/7",DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        0);
        run_op("div 7/-2",  DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 0);
        run_op("mult 7*-6", MULT,  32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0);
        step();
        chk("done one cycle", {31'd0, done}, 32'd0);

        // Direct writes while idle.
        hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hDEAD_BEEF;
        step();
        hilo_we = 1'b0;
        chk("mthi hi", hi, 32'hDEAD_BEEF);
        chk("mthi lo kept", lo, 32'hFFFF_FFD6);
        hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h0BAD_F00D;
        step();
        hilo_we = 1'b0;
        chk("mtlo lo", lo, 32'h0BAD_F00D);
        chk("mtlo hi kept", hi, 32'hDEAD_BEEF);

        // Foreign start and direct writes while busy are ignored.
        run_op("multu 6*7 busy", MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1);
        // Direct write with accepted start lands, then the result overwrites it.
        run_op("multu 3*4 we", MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 2);
        step();

        // Reset in cycle 10 of a MULTU aborts it with no done pulse.
        start = 1'b1; op = MULTU; a = 32'd1000; b = 32'd1000;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        for (int c = 12; c <= 50; c++) begin
            step();
            chk($sformatf("abort no done c%0d", c), {31'd0, done}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the processor's execute stage. It consumes the two source operands read from the register file (RD1 → `a`, RD2 → `b`) and produces a 64-bit result in architectural HI/LO registers. Those registers are later read back into the register-file write-data path. The unit runs MULT, MULTU, DIV and DIVU over 32 iteration cycles, with a start/busy/done handshake toward the pipeline control.

## Interface
- `WIDTH`, 32, operand width; the iteration count equals `WIDTH`.

- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: launch the operation selected by `op`; sampled only when `busy`=0.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` in WIDTH: multiplicand or dividend (RD1).
- `b` in WIDTH: multiplier or divisor (RD2).
- `hilo_we` in 1: direct write to HI/LO (MTHI/MTLO).
- `hilo_sel` in 1: target of the direct write; 0 = LO, 1 = HI.
- `hilo_wdata` in WIDTH: data for the direct write.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; HI/LO hold the new result.
- `hi` out WIDTH: HI register; product upper half, or remainder.
- `lo` out WIDTH: LO register; product lower half, or quotient.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE, `start`=1:
  - latch |a| and |b| (signed ops) or raw a and b (unsigned ops)
  - record the result signs
  - clear the 64-bit accumulator and the iteration counter
  - go to RUN
- RUN: one iteration per cycle.
  - Multiply: shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring; shift in one dividend bit, trial-subtract the divisor, set the quotient bit.
  - After `WIDTH` iterations go to FIX.
- FIX:
  - apply sign correction (two's-complement negate)
  - write HI/LO
  - register `done`=1
  - return to IDLE
- Sign rules:
  - MULT: 64-bit product is negative iff the operand signs differ.
  - DIV: quotient is negative iff the signs differ; remainder takes the sign of the dividend.
  - The unsigned ops apply no correction.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude datapath; no special case.
- Divide by zero (DIV or DIVU):
  - normal latency, no trap
  - LO=0xFFFFFFFF, HI=original `a`, no sign correction
- `start` while `busy`=1: ignored; the operation in flight is unaffected.
- `hilo_we`:
  - Honoured only when `busy`=0; ignored otherwise, including during FIX.
  - Takes effect on the next edge.
  - Asserted together with an accepted `start`: the write lands, then the operation result overwrites it at completion.
- `start` in the cycle `done`=1 is accepted (`busy` is 0 then).
- HI/LO change only at FIX completion, on a direct write, or on reset.

## Timing
- Reset values:
  - state IDLE, counter 0
  - `busy`=0, `done`=0
  - `hi`=0, `lo`=0
  - accumulator and operand latches 0
- Reset takes priority over every other input.
- Reset mid-operation: aborts next edge; no `done` pulse; HI/LO cleared.
- Start accepted in cycle N:
  - `busy`=1 in cycles N+1 through N+33
  - `done`=1 in cycle N+34 only
  - `hi`/`lo` valid from cycle N+34
  - `busy`=0 in cycle N+34
- Total latency: 34 cycles from the start cycle to the done cycle. It is fixed and independent of operand values; there is no early termination.
- Back-to-back: a start in cycle N+34 gives the next `done` in cycle N+68.
- `busy` and `done` are registered outputs; there is no combinational path from inputs to outputs.
- `hi`/`lo` are direct register outputs.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start in cycle 0 → `done` only in cycle 34; HI=0xFFFFFFFE, LO=0x00000001; `busy` high in cycles 1–33.
- MULT a=0xFFFFFFFD (−3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU a=7, b=0 → LO=0xFFFFFFFF, HI=7, at normal latency.
- Reset asserted in cycle 10 of a MULTU → `busy`=0 from cycle 11, HI=LO=0, and no `done` in any later cycle.
- Second `start` (DIVU 9/3) in cycle 5 during a MULTU 6×7 → ignored; HI=0, LO=42 at cycle 34.
- `hilo_we` during a run → ignored.
- `hilo_we`=1, `hilo_sel`=1, `hilo_wdata`=0xDEADBEEF while idle → HI=0xDEADBEEF next cycle; LO unchanged.
